// File: rtl/sad_pkg.sv
// Shared SAD-path definitions: kernel geometry, pixel/column types, row-rotation helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sad_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int HRES        = 320;
  localparam int VRES        = 240;

  // Rows between the top of the kernel and its centre row
  localparam int HALF   = (KERNEL_SIZE - 1) / 2;
  localparam int ADDR_W = $clog2(HRES);
  localparam int SEL_W  = $clog2(KERNEL_SIZE);

  typedef logic [7:0] pixel_t;
  typedef pixel_t [KERNEL_SIZE-1:0] column_t;

  // Line RAM holding the line written k lines before the one in RAM[sel]
  function automatic logic [SEL_W-1:0] row_sel(input logic [SEL_W-1:0] sel, input int k);
    int t;
    t = (int'(sel) + KERNEL_SIZE - k) % KERNEL_SIZE;
    return SEL_W'(t);
  endfunction

  // Next line RAM in rotation order
  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] sel);
    return (int'(sel) == KERNEL_SIZE - 1) ? '0 : sel + 1'b1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One stored video line: HRES x 8, single write port and single read port.
// Latency: 1 cycle read, read-first when reading and writing the same address.
// Backpressure: none; a write and a read may be issued every cycle.
module line_ram
  import sad_pkg::*;
(
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data
);

  pixel_t mem [HRES];

  // Write and registered read; nonblocking update gives old data on a same-address read
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/kernel_line_buffer.sv
// Line buffer feeding the SAD stage: emits a KERNEL_SIZE x 1 pixel column per accepted pixel
// with vcount re-centred on the middle row. Latency: 2 cycles accept -> data_valid_out.
// Backpressure: none, one column per cycle. Optional KLB_ZERO_BORDER_EN zeroes rows above line 0.
module kernel_line_buffer
  import sad_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  data_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  output column_t     data_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out
);

  logic              accept;
  logic              resync;
  logic              line_end;
  logic [SEL_W-1:0]  wr_sel;
  logic [SEL_W-1:0]  sel_eff;
  logic [ADDR_W-1:0] addr;
  logic [9:0]        vc_centred;
  pixel_t            rd_dat [KERNEL_SIZE];

  // Stage 1: aligned with the line RAM read data
  logic              s1_vld;
  pixel_t            s1_pix;
  logic [SEL_W-1:0]  s1_sel;
  logic [10:0]       s1_hc;
  logic [9:0]        s1_vc;
  column_t           col_next;

`ifdef KLB_ZERO_BORDER_EN
  logic [SEL_W-1:0]  rows_filled;
  logic [SEL_W-1:0]  fill_eff;
  logic [SEL_W-1:0]  s1_fill;
`endif

  // Input qualification; a frame start pins the write to RAM[0]
  always_comb begin
    accept     = data_valid_in && !rst_in &&
                 (hcount_in < 11'(HRES)) && (vcount_in < 10'(VRES));
    resync     = accept && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    line_end   = accept && (hcount_in == 11'(HRES - 1));
    sel_eff    = resync ? '0 : wr_sel;
    addr       = hcount_in[ADDR_W-1:0];
    vc_centred = (vcount_in >= 10'(HALF)) ? (vcount_in - 10'(HALF))
                                          : (vcount_in + 10'(VRES - HALF));
  end

  generate
    for (genvar g = 0; g < KERNEL_SIZE; g++) begin : g_ram
      line_ram u_line_ram (
        .clk_in  (clk_in),
        .wr_en   (accept && (sel_eff == SEL_W'(g))),
        .wr_addr (addr),
        .wr_data (data_in),
        .rd_en   (accept),
        .rd_addr (addr),
        .rd_data (rd_dat[g])
      );
    end
  endgenerate

`ifdef KLB_ZERO_BORDER_EN
  always_comb fill_eff = resync ? '0 : rows_filled;

  // Count completed lines of the current frame, saturating once the kernel is full
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rows_filled <= '0;
      s1_fill     <= '0;
    end else if (accept) begin
      s1_fill     <= fill_eff;
      rows_filled <= (line_end && int'(fill_eff) != KERNEL_SIZE - 1) ? fill_eff + 1'b1
                                                                      : fill_eff;
    end
  end
`endif

  // Write-select rotation and stage-1 capture of the accepted pixel
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_sel <= '0;
      s1_vld <= 1'b0;
      s1_pix <= '0;
      s1_sel <= '0;
      s1_hc  <= '0;
      s1_vc  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_pix <= data_in;
        s1_sel <= sel_eff;
        s1_hc  <= hcount_in;
        s1_vc  <= vc_centred;
        wr_sel <= line_end ? sel_next(sel_eff) : sel_eff;
      end
    end
  end

  // Order RAM outputs oldest-first behind the current pixel
  always_comb begin
    col_next = '0;
    col_next[KERNEL_SIZE-1] = s1_pix;
    for (int k = 1; k < KERNEL_SIZE; k++) begin
      col_next[KERNEL_SIZE-1-k] = rd_dat[row_sel(s1_sel, k)];
    end
`ifdef KLB_ZERO_BORDER_EN
    for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
      if (int'(s1_fill) < KERNEL_SIZE - 1 - i) col_next[i] = '0;
    end
`endif
  end

  // Output registers hold their last column while nothing valid arrives
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_out       <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= s1_vld;
      if (s1_vld) begin
        data_out   <= col_next;
        hcount_out <= s1_hc;
        vcount_out <= s1_vc;
      end
    end
  end

endmodule
